// File: rtl/oka_pkg.sv
// Shared widths and bit-shuffling helpers for the overlap-free Karatsuba
// carry-less multiplier (even/odd split and result interleave).
package oka_pkg;

    localparam int unsigned OKA_W  = 32;
    localparam int unsigned OKA_HW = 16;
    localparam int unsigned OKA_YW = 63;

    // Pick the even (odd=0) or odd (odd=1) coefficients of a 32-bit polynomial.
    function automatic logic [OKA_HW-1:0] oka_split(input logic [OKA_W-1:0] v,
                                                    input logic             odd);
        logic [OKA_HW-1:0] r;
        r = '0;
        for (int k = 0; k < OKA_HW; k++) begin
            r[k] = odd ? v[2*k+1] : v[2*k];
        end
        return r;
    endfunction

    // y[2k] = P0[k] ^ P1[k-1], y[2k+1] = M[k]; padding supplies P0[31]=0 and P1[-1]=0.
    function automatic logic [OKA_YW-1:0] oka_interleave(input logic [2*OKA_HW-2:0] p0,
                                                         input logic [2*OKA_HW-2:0] p1,
                                                         input logic [2*OKA_HW-2:0] m);
        logic [OKA_YW-1:0]  r;
        logic [2*OKA_HW-1:0] p0x;
        logic [2*OKA_HW-1:0] p1x;
        p0x = {1'b0, p0};
        p1x = {p1, 1'b0};
        r   = '0;
        for (int k = 0; k < 2*OKA_HW; k++) begin
            r[2*k] = p0x[k] ^ p1x[k];
        end
        for (int k = 0; k < 2*OKA_HW-1; k++) begin
            r[2*k+1] = m[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/oka_clmul_16bit.sv
// Combinational 16x16 -> 31-bit carry-less multiplier (schoolbook AND/XOR array).
module oka_clmul_16bit
    import oka_pkg::*;
(
    input  logic [OKA_HW-1:0]   a_i,
    input  logic [OKA_HW-1:0]   b_i,
    output logic [2*OKA_HW-2:0] p_o
);

    always_comb begin
        p_o = '0;
        for (int i = 0; i < OKA_HW; i++) begin
            if (b_i[i]) begin
                p_o = p_o ^ ({{(OKA_HW-1){1'b0}}, a_i} << i);
            end
        end
    end

endmodule

// File: rtl/oka_clmul_32bit.sv
// Pipelined 32x32 -> 63-bit carry-less multiplier, one overlap-free Karatsuba level.
// Define OKA_PIPE_EN to register P0/P1/P2 (latency 3 instead of 2).
module oka_clmul_32bit
    import oka_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [OKA_W-1:0]  a,
    input  logic [OKA_W-1:0]  b,
    output logic              out_valid,
    output logic [OKA_YW-1:0] y
);

    logic [OKA_W-1:0]    a_q, a_d;
    logic [OKA_W-1:0]    b_q, b_d;
    logic                vld_q, vld_d;
    logic [OKA_YW-1:0]   y_q, y_d;
    logic                out_valid_q, out_valid_d;

    logic [OKA_HW-1:0]   ae, ao, be, bo;
    logic [2*OKA_HW-2:0] p0, p1, p2;
    logic [2*OKA_HW-2:0] p0_s, p1_s, p2_s;
    logic                vld_s;

    always_comb begin
        a_d   = a;
        b_d   = b;
        vld_d = in_valid;
        ae    = oka_split(a_q, 1'b0);
        ao    = oka_split(a_q, 1'b1);
        be    = oka_split(b_q, 1'b0);
        bo    = oka_split(b_q, 1'b1);
    end

    oka_clmul_16bit u_p0 (.a_i(ae),      .b_i(be),      .p_o(p0));
    oka_clmul_16bit u_p1 (.a_i(ao),      .b_i(bo),      .p_o(p1));
    oka_clmul_16bit u_p2 (.a_i(ae ^ ao), .b_i(be ^ bo), .p_o(p2));

`ifdef OKA_PIPE_EN
    logic [2*OKA_HW-2:0] p0_q, p1_q, p2_q;
    logic                vld_p_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            vld_p_q <= 1'b0;
        end else begin
            p0_q    <= p0;
            p1_q    <= p1;
            p2_q    <= p2;
            vld_p_q <= vld_q;
        end
    end

    always_comb begin
        p0_s  = p0_q;
        p1_s  = p1_q;
        p2_s  = p2_q;
        vld_s = vld_p_q;
    end
`else
    always_comb begin
        p0_s  = p0;
        p1_s  = p1;
        p2_s  = p2;
        vld_s = vld_q;
    end
`endif

    // Middle term M = P2^P0^P1 lands only on odd bits, so no overlap with even bits.
    always_comb begin
        y_d         = oka_interleave(p0_s, p1_s, p2_s ^ p0_s ^ p1_s);
        out_valid_d = vld_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            vld_q       <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            vld_q       <= vld_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_oka_clmul_32bit.sv
// Scoreboard bench for oka_clmul_32bit: directed vectors, random stream, mid-stream reset.
module tb_oka_clmul_32bit;

`ifdef OKA_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic [62:0] y;

    oka_clmul_32bit dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .y        (y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [62:0] y;
        int          issue;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [62:0] clmul_ref(input logic [31:0] x, input logic [31:0] z);
        logic [62:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (z[i]) r = r ^ ({31'b0, x} << i);
        end
        return r;
    endfunction

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input bit v,
                         input logic [62:0] ey);
        @(negedge clk);
        a        = ta;
        b        = tb;
        in_valid = v;
        if (v) sbq.push_back('{y: ey, issue: cyc});
    endtask

    task automatic chk(input string name, input logic [62:0] got, input logic [62:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a result.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: got y=%h with no pending pair at cycle %0d",
                             y, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    checks += 2;
                    if (y !== mon_e.y) begin
                        errors++;
                        $display("FAIL result: got %h expected %h", y, mon_e.y);
                    end
                    if (cyc - mon_e.issue != LAT) begin
                        errors++;
                        $display("FAIL latency: got %0d expected %0d", cyc - mon_e.issue, LAT);
                    end
                end
            end else if (sbq.size() > 0 && cyc - sbq[0].issue > LAT) begin
                mon_e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_result: got no out_valid expected y=%h", mon_e.y);
            end
        end
    end

    initial begin
        #12;
        chk("reset_out_valid", {62'b0, out_valid}, 63'd0);
        chk("reset_y", y, 63'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(32'h0000_0001, 32'h1234_5678, 1'b1, 63'h0000_0000_1234_5678);
        issue(32'h0000_0000, 32'h0000_0000, 1'b0, 63'd0);
        issue(32'h0000_0003, 32'h0000_0003, 1'b1, 63'h5);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 63'h4000_0000_0000_0000);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 63'h5555_5555_5555_5555);
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 63'd0);
        issue(32'h0000_0005, 32'h0000_0003, 1'b1, 63'hF);
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 63'h0000_0000_FFFF_FFFF);
        issue(32'h8000_0001, 32'h8000_0001, 1'b1, 63'h4000_0000_0000_0001);
        issue(32'd4128831000, 32'd3997757000, 1'b1, clmul_ref(32'd4128831000, 32'd3997757000));
        for (int i = 0; i < LAT + 3; i++) issue(32'h0, 32'h0, 1'b0, 63'd0);

        // Two pairs in flight, then asynchronous reset between clock edges.
        issue(32'h0000_0001, 32'h1234_5678, 1'b1, 63'h0000_0000_1234_5678);
        issue(32'h0000_0003, 32'h0000_0003, 1'b1, 63'h5);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        sbq.delete();
        #1;
        chk("rst_mid_out_valid", {62'b0, out_valid}, 63'd0);
        chk("rst_mid_y", y, 63'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < LAT + 3; i++) issue(32'h0, 32'h0, 1'b0, 63'd0);
        issue(32'h0000_0005, 32'h0000_0003, 1'b1, 63'hF);
        for (int i = 0; i < LAT + 3; i++) issue(32'h0, 32'h0, 1'b0, 63'd0);

        for (int i = 0; i < 10000; i++) begin
            logic [31:0] ra, rb;
            bit          rv;
            ra = $urandom;
            rb = $urandom;
            rv = ($urandom_range(0, 3) != 0);
            issue(ra, rb, rv, clmul_ref(ra, rb));
        end
        for (int i = 0; i < LAT + 3; i++) issue(32'h0, 32'h0, 1'b0, 63'd0);

        chk("scoreboard_drained", 63'(sbq.size()), 63'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
